// File: rtl/id_ex_pipe_buf_pkg.sv
// Shared widths and the ID->EX payload record carried by every pipeline slot.
// A bubble is the all-zero payload, so PAYLOAD_ZERO doubles as the cleared slot value.
package pipe_pkg;

    localparam int ALUSEL_W  = 8;
    localparam int XLEN      = 32;
    localparam int IMM_W     = 32;
    localparam int ADDR_W    = 32;
    localparam int REGADDR_W = 5;

    typedef struct packed {
        logic [ALUSEL_W-1:0]  alusel;
        logic [XLEN-1:0]      opr1;
        logic [XLEN-1:0]      opr2;
        logic [IMM_W-1:0]     imm;
        logic [ADDR_W-1:0]    pc;
        logic [REGADDR_W-1:0] wd;
        logic                 wreg;
    } id_ex_payload_t;

    localparam id_ex_payload_t PAYLOAD_ZERO = '0;

endpackage

// File: rtl/id_ex_pipe_buf_if.sv
// ID->EX handshake bundle: ID pushes with in_valid/in_ready, EX pops with out_valid/out_ready.
// A transfer happens on a rising edge where valid && ready on the same side.
interface id_ex_pipe_buf_if;
    import pipe_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [ALUSEL_W-1:0]  in_alusel;
    logic [XLEN-1:0]      in_opr1;
    logic [XLEN-1:0]      in_opr2;
    logic [IMM_W-1:0]     in_imm;
    logic [ADDR_W-1:0]    in_pc;
    logic [REGADDR_W-1:0] in_wd;
    logic                 in_wreg;

    logic                 out_valid;
    logic                 out_ready;
    logic [ALUSEL_W-1:0]  out_alusel;
    logic [XLEN-1:0]      out_opr1;
    logic [XLEN-1:0]      out_opr2;
    logic [IMM_W-1:0]     out_imm;
    logic [ADDR_W-1:0]    out_pc;
    logic [REGADDR_W-1:0] out_wd;
    logic                 out_wreg;

    modport master (
        output in_valid, in_alusel, in_opr1, in_opr2, in_imm, in_pc, in_wd, in_wreg, out_ready,
        input  in_ready, out_valid, out_alusel, out_opr1, out_opr2, out_imm, out_pc, out_wd,
               out_wreg
    );

    modport slave (
        input  in_valid, in_alusel, in_opr1, in_opr2, in_imm, in_pc, in_wd, in_wreg, out_ready,
        output in_ready, out_valid, out_alusel, out_opr1, out_opr2, out_imm, out_pc, out_wd,
               out_wreg
    );

endinterface

// File: rtl/id_ex_pipe_buf_slot.sv
// One pipeline slot: payload register plus valid bit. clear_i wins over load_i, and a
// cleared slot always holds the all-zero bubble payload.
module pipe_slot
    import pipe_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           clear_i,
    input  id_ex_payload_t d_i,
    output logic           valid_o,
    output id_ex_payload_t q_o
);

    logic           valid_q, valid_d;
    id_ex_payload_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = PAYLOAD_ZERO;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= PAYLOAD_ZERO;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = data_q;

endmodule

// File: rtl/id_ex_pipe_buf.sv
// ID->EX pipeline register with flush and a saturating stall counter.
// Define PIPE_SKID_EN for a head+skid pair that makes in_ready a registered signal.
module id_ex_pipe_buf
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    id_ex_pipe_buf_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt
);

    id_ex_payload_t in_pl;
    id_ex_payload_t head_q;
    id_ex_payload_t head_d;
    logic           head_valid;
    logic           head_load;
    logic           head_clear;
    logic           in_ready;
    logic           push;
    logic           pop;

    assign in_pl = '{alusel: bus.in_alusel, opr1: bus.in_opr1, opr2: bus.in_opr2,
                     imm: bus.in_imm, pc: bus.in_pc, wd: bus.in_wd, wreg: bus.in_wreg};

    assign push = bus.in_valid && in_ready;
    assign pop  = head_valid && bus.out_ready;

`ifdef PIPE_SKID_EN
    id_ex_payload_t skid_q;
    logic           skid_valid;
    logic           skid_load;
    logic           skid_clear;

    // The skid only ever holds an entry while the head is valid, so a pop always has
    // something older than the input to promote first.
    assign in_ready   = !skid_valid;
    assign head_load  = !flush && ((!head_valid && push) || (pop && (skid_valid || push)));
    assign head_clear = flush || (pop && !skid_valid && !push);
    assign head_d     = skid_valid ? skid_q : in_pl;
    assign skid_load  = !flush && push && head_valid && !pop;
    assign skid_clear = flush || (pop && skid_valid);

    pipe_slot u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .d_i     (in_pl),
        .valid_o (skid_valid),
        .q_o     (skid_q)
    );
`else
    assign in_ready   = !head_valid || bus.out_ready;
    assign head_load  = !flush && push;
    assign head_clear = flush || (pop && !push);
    assign head_d     = in_pl;
`endif

    pipe_slot u_head (
        .clk     (clk),
        .rst     (rst),
        .load_i  (head_load),
        .clear_i (head_clear),
        .d_i     (head_d),
        .valid_o (head_valid),
        .q_o     (head_q)
    );

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = head_valid;
    assign bus.out_alusel = head_q.alusel;
    assign bus.out_opr1   = head_q.opr1;
    assign bus.out_opr2   = head_q.opr2;
    assign bus.out_imm    = head_q.imm;
    assign bus.out_pc     = head_q.pc;
    assign bus.out_wd     = head_q.wd;
    assign bus.out_wreg   = head_q.wreg && head_valid;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturates rather than wraps; a flush cycle is not counted as a stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (head_valid && !bus.out_ready && !flush && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_buf.sv
// Directed self-checking bench for id_ex_pipe_buf (4-bit stall counter instance).
// Expectations adapt to PIPE_SKID_EN through DEPTH, the number of entries the buffer can hold.
module tb_id_ex_pipe_buf;
    import pipe_pkg::*;

`ifdef PIPE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk;
    logic       rst;
    logic       flush;
    logic [3:0] stall_cnt;
    int         n_cmp;
    int         n_err;
    logic [31:0] exp_q[$];

    id_ex_pipe_buf_if bus ();

    id_ex_pipe_buf #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_in(input logic v, input logic [31:0] pc);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_alusel = pc[9:2];
        bus.in_opr1   = 32'hA000_0000 | pc;
        bus.in_opr2   = 32'hB000_0000 | pc;
        bus.in_imm    = 32'hC000_0000 | pc;
        bus.in_wd     = pc[6:2];
        bus.in_wreg   = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        logic [31:0] p;
        p = pc;
        check_val({tag, "_valid"},  bus.out_valid,  1);
        check_val({tag, "_pc"},     bus.out_pc,     p);
        check_val({tag, "_alusel"}, bus.out_alusel, p[9:2]);
        check_val({tag, "_opr1"},   bus.out_opr1,   32'hA000_0000 | p);
        check_val({tag, "_opr2"},   bus.out_opr2,   32'hB000_0000 | p);
        check_val({tag, "_imm"},    bus.out_imm,    32'hC000_0000 | p);
        check_val({tag, "_wd"},     bus.out_wd,     p[6:2]);
        check_val({tag, "_wreg"},   bus.out_wreg,   1);
    endtask

    task automatic check_bubble(input string tag);
        check_val({tag, "_valid"},  bus.out_valid,  0);
        check_val({tag, "_pc"},     bus.out_pc,     0);
        check_val({tag, "_alusel"}, bus.out_alusel, 0);
        check_val({tag, "_opr1"},   bus.out_opr1,   0);
        check_val({tag, "_opr2"},   bus.out_opr2,   0);
        check_val({tag, "_imm"},    bus.out_imm,    0);
        check_val({tag, "_wd"},     bus.out_wd,     0);
        check_val({tag, "_wreg"},   bus.out_wreg,   0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] nxt_pc;
        n_cmp = 0;
        n_err = 0;

        // Reset held for two edges while ID presents an instruction
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(1'b1, 32'h100);
        tick();
        tick();
        check_bubble("rst");
        check_val("rst_stall_cnt", stall_cnt, 0);
        rst = 1'b0;
        drive_in(1'b0, 32'h0);
        #1;
        check_val("rst_in_ready", bus.in_ready, 1);
        tick();
        check_bubble("rst_idle");
        check_val("rst_idle_in_ready", bus.in_ready, 1);

        // Streaming: one instruction per cycle, 1-cycle latency, no gaps
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_in(1'b1, 32'(i * 4));
            exp_q.push_back(32'(i * 4));
            #1;
            check_val("stream_in_ready", bus.in_ready, 1);
            tick();
            check_head("stream", exp_q.pop_front());
        end
        drive_in(1'b0, 32'h0);
        tick();
        check_bubble("stream_end");
        check_val("stream_stall_cnt", stall_cnt, 0);

        // Stall: EX holds off; head loads on cycle 0, then 5 stall edges follow
        bus.out_ready = 1'b0;
        nxt_pc = 32'h20;
        for (int c = 0; c < 6; c++) begin
            logic exp_rdy;
            exp_rdy = (c < DEPTH);
            drive_in(1'b1, nxt_pc);
            #1;
            check_val("stall_in_ready", bus.in_ready, exp_rdy);
            if (exp_rdy) begin
                exp_q.push_back(nxt_pc);
                nxt_pc = nxt_pc + 32'h4;
            end
            tick();
            check_head("stall_hold", 32'h20);
            check_val("stall_cnt_run", stall_cnt, c);
        end
        check_val("stall_cnt_5", stall_cnt, 5);
        drive_in(1'b0, 32'h0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
            tick();
            void'(exp_q.pop_front());
            if (exp_q.size() > 0) check_head("stall_drain", exp_q[0]);
            else                  check_bubble("stall_drained");
        end
        check_val("stall_cnt_after_drain", stall_cnt, 5);

        // Flush: fill the buffer, then flush with a same-cycle push of pc=0x40
        bus.out_ready = 1'b0;
        drive_in(1'b1, 32'h30);
        tick();
        check_val("flush_cnt_a", stall_cnt, 5);
        drive_in(1'b1, 32'h34);
        #1;
        check_val("flush_in_ready_b", bus.in_ready, DEPTH == 2);
        tick();
        check_head("flush_pre", 32'h30);
        check_val("flush_cnt_b", stall_cnt, 6);
        drive_in(1'b1, 32'h40);
        flush = 1'b1;
        #1;
        check_val("flush_in_ready_full", bus.in_ready, 0);
        tick();
        flush = 1'b0;
        drive_in(1'b0, 32'h0);
        check_bubble("flush_post");
        check_val("flush_cnt_kept", stall_cnt, 6);
        bus.out_ready = 1'b1;
        tick();
        check_bubble("flush_no_0x40");
        check_val("flush_cnt_final", stall_cnt, 6);

        // Simultaneous push/pop on a full head
        drive_in(1'b1, 32'h10);
        tick();
        check_head("pp_first", 32'h10);
        drive_in(1'b1, 32'h14);
        #1;
        check_val("pp_in_ready", bus.in_ready, 1);
        tick();
        check_head("pp_replace", 32'h14);
        drive_in(1'b0, 32'h0);
        tick();
        check_bubble("pp_end");

        // Saturation of the 4-bit counter over 20 stall edges
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("sat_cnt_reset", stall_cnt, 0);
        bus.out_ready = 1'b0;
        drive_in(1'b1, 32'h50);
        tick();
        drive_in(1'b0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 13) check_val("sat_cnt_14", stall_cnt, 14);
        end
        check_val("sat_cnt_15", stall_cnt, 15);
        check_head("sat_hold", 32'h50);
        for (int k = 0; k < 3; k++) tick();
        check_val("sat_cnt_stays", stall_cnt, 15);

        // Reset overrides a simultaneous flush and push mid-operation
        rst = 1'b1;
        flush = 1'b1;
        drive_in(1'b1, 32'h60);
        tick();
        rst = 1'b0;
        flush = 1'b0;
        drive_in(1'b0, 32'h0);
        check_bubble("rst_mid");
        check_val("rst_mid_cnt", stall_cnt, 0);
        tick();
        check_bubble("rst_mid_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
